drawbridge_ctrl: RTL and testbench

DRAWBRIDGE_CTRL -- requirements
Module: drawbridge_ctrl

---
 rtl/drawbridge_pkg.sv | 41 ++++
 rtl/drawbridge_timer.sv | 28 ++
 rtl/drawbridge_ctrl.sv | 150 +++++++++++++++
 tb/tb_drawbridge_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drawbridge_pkg.sv
// Drawbridge controller shared types: state encoding, output decode.
// Outputs packed {mt_up, mt_down, al, tfl}; FAULT used with DRAWBRIDGE_FAULT_EN.
package drawbridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WARN  = 3'd1,
    S_RAISE = 3'd2,
    S_OPEN  = 3'd3,
    S_LOWER = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [3:0] OUT_IDLE  = 4'b0000;
  localparam logic [3:0] OUT_WARN  = 4'b0011;
  localparam logic [3:0] OUT_RAISE = 4'b1011;
  localparam logic [3:0] OUT_OPEN  = 4'b0001;
  localparam logic [3:0] OUT_LOWER = 4'b0111;
  localparam logic [3:0] OUT_FAULT = 4'b0011;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [3:0] out_decode(state_t s);
    logic [3:0] o;
    unique case (s)
      S_IDLE:  o = OUT_IDLE;
      S_WARN:  o = OUT_WARN;
      S_RAISE: o = OUT_RAISE;
      S_OPEN:  o = OUT_OPEN;
      S_LOWER: o = OUT_LOWER;
      S_FAULT: o = OUT_FAULT;
      default: o = OUT_FAULT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/drawbridge_timer.sv
// Down-counter: load, decrement, saturate at zero, zero flag.
// Ports: clk, rst (async high), load, dec, value -> count, zero.
module drawbridge_timer
  import drawbridge_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (dec && !zero)
      count <= count - W'(1);
  end

endmodule

// File: rtl/drawbridge_ctrl.sv
// Drawbridge sequencer: warn, raise, hold open, lower; Moore outputs.
// Ports: Clock, Reset (async high), BoatReq, DeckOccupied, UpLimit,
// DownLimit -> MT_UP, MT_DOWN, AL, TFL, State.
// Optional macro DRAWBRIDGE_FAULT_EN adds motor timeout and FAULT.
module drawbridge_ctrl
  import drawbridge_pkg::*;
#(
  parameter int N_DECK        = 6,
  parameter int CLEAR_CYCLES  = 16,
  parameter int HOLD_CYCLES   = 32,
  parameter int MOTOR_TIMEOUT = 256
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              BoatReq,
  input  logic [N_DECK-1:0] DeckOccupied,
  input  logic              UpLimit,
  input  logic              DownLimit,
  output logic              MT_UP,
  output logic              MT_DOWN,
  output logic              AL,
  output logic              TFL,
  output logic [2:0]        State
);

  localparam int MAXP =
    max3(CLEAR_CYCLES, HOLD_CYCLES, MOTOR_TIMEOUT);
  localparam int TW = $clog2(MAXP) + 1;

  localparam logic [TW-1:0] CLR_V = TW'(CLEAR_CYCLES);
  localparam logic [TW-1:0] HLD_V = TW'(HOLD_CYCLES);

  state_t st, nxt;

  logic          t_load, t_dec, t_zero, t_exp;
  logic [TW-1:0] t_val, t_cnt;

  // Expiry is judged on the value the decrement lands on, so a
  // load of N gives exactly N cycles in the waiting state.
  assign t_exp = t_zero | (t_cnt == TW'(1));

  drawbridge_timer #(.W(TW)) u_tmr (
    .clk   (Clock),
    .rst   (Reset),
    .load  (t_load),
    .dec   (t_dec),
    .value (t_val),
    .count (t_cnt),
    .zero  (t_zero)
  );

`ifdef DRAWBRIDGE_FAULT_EN
  logic          m_load, m_dec, m_zero, m_exp;
  logic [TW-1:0] m_cnt;

  // Reloaded on every entry to a motion state, including reopen.
  assign m_load = (nxt != st) &&
                  (nxt == S_RAISE || nxt == S_LOWER);
  assign m_dec  = (st == S_RAISE || st == S_LOWER);
  assign m_exp  = m_zero | (m_cnt == TW'(1));

  drawbridge_timer #(.W(TW)) u_mot (
    .clk   (Clock),
    .rst   (Reset),
    .load  (m_load),
    .dec   (m_dec),
    .value (TW'(MOTOR_TIMEOUT)),
    .count (m_cnt),
    .zero  (m_zero)
  );
`endif

  always_comb begin
    nxt    = st;
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_val  = '0;
    unique case (st)
      S_IDLE: begin
        if (!DownLimit)
          nxt = S_LOWER;
        else if (BoatReq) begin
          nxt    = S_WARN;
          t_load = 1'b1;
          t_val  = CLR_V;
        end
      end
      S_WARN: begin
        t_dec = 1'b1;
        if (t_exp && !(|DeckOccupied))
          nxt = S_RAISE;
      end
      S_RAISE: begin
        if (UpLimit) begin
          nxt    = S_OPEN;
          t_load = 1'b1;
          t_val  = HLD_V;
        end
`ifdef DRAWBRIDGE_FAULT_EN
        else if (m_exp)
          nxt = S_FAULT;
`endif
      end
      S_OPEN: begin
        if (BoatReq) begin
          t_load = 1'b1;
          t_val  = HLD_V;
        end else begin
          t_dec = 1'b1;
          if (t_exp)
            nxt = S_LOWER;
        end
      end
      S_LOWER: begin
        if (DownLimit)
          nxt = S_IDLE;
`ifdef DRAWBRIDGE_FAULT_EN
        else if (m_exp)
          nxt = S_FAULT;
`endif
        else if (BoatReq)
          nxt = S_RAISE;
      end
`ifdef DRAWBRIDGE_FAULT_EN
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_FAULT;
`else
      default: nxt = S_LOWER;
`endif
    endcase
`ifdef DRAWBRIDGE_FAULT_EN
    // Both limits closed means a broken switch: stop everything.
    if (UpLimit && DownLimit)
      nxt = S_FAULT;
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      st                       <= S_IDLE;
      {MT_UP, MT_DOWN, AL, TFL} <= OUT_IDLE;
    end else begin
      st                       <= nxt;
      {MT_UP, MT_DOWN, AL, TFL} <= out_decode(nxt);
    end
  end

  assign State = st;

endmodule

// File: tb/tb_drawbridge_ctrl.sv
// Self-checking bench for drawbridge_ctrl with a bridge plant model.
// Optional macro DRAWBRIDGE_FAULT_EN enables the fault scenarios.
module tb_drawbridge_ctrl;

  localparam int ND  = 4;
  localparam int CLR = 8;
  localparam int HLD = 5;
  localparam int MTO = 20;
`ifdef DRAWBRIDGE_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset;
  logic          BoatReq;
  logic [ND-1:0] DeckOccupied;
  logic          UpLimit;
  logic          DownLimit;
  logic          MT_UP, MT_DOWN, AL, TFL;
  logic [2:0]    State;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: state id plus elapsed-cycle counters
  int m_st, m_age, m_quiet, m_mage;
  int pos;
  bit plant_en;

  drawbridge_ctrl #(
    .N_DECK        (ND),
    .CLEAR_CYCLES  (CLR),
    .HOLD_CYCLES   (HLD),
    .MOTOR_TIMEOUT (MTO)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .BoatReq      (BoatReq),
    .DeckOccupied (DeckOccupied),
    .UpLimit      (UpLimit),
    .DownLimit    (DownLimit),
    .MT_UP        (MT_UP),
    .MT_DOWN      (MT_DOWN),
    .AL           (AL),
    .TFL          (TFL),
    .State        (State)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // {mt_up, mt_down, al, tfl} for a model state
  function automatic logic [3:0] lamp(int s);
    case (s)
      0:       return 4'b0000;
      1:       return 4'b0011;
      2:       return 4'b1011;
      3:       return 4'b0001;
      4:       return 4'b0111;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic logic [31:0] obs();
    return {25'd0, State, MT_UP, MT_DOWN, AL, TFL};
  endfunction

  function automatic logic [31:0] want();
    return {25'd0, 3'(m_st), lamp(m_st)};
  endfunction

  task automatic mreset();
    m_st = 0; m_age = 0; m_quiet = 0; m_mage = 0;
  endtask

  task automatic model_step();
    int ns;
    ns = m_st;
    case (m_st)
      0: if (!DownLimit) ns = 4;
         else if (BoatReq) ns = 1;
      1: if (m_age + 1 >= CLR && DeckOccupied == 0) ns = 2;
      2: if (UpLimit) ns = 3;
         else if (FEN && m_mage + 1 >= MTO) ns = 5;
      3: if (!BoatReq && m_quiet + 1 >= HLD) ns = 4;
      4: if (DownLimit) ns = 0;
         else if (FEN && m_mage + 1 >= MTO) ns = 5;
         else if (BoatReq) ns = 2;
      default: ns = 5;
    endcase
    if (FEN && UpLimit && DownLimit) ns = 5;
    if (ns != m_st) begin
      m_age = 0; m_quiet = 0; m_mage = 0;
    end else begin
      m_age++;
      m_mage++;
      m_quiet = BoatReq ? 0 : m_quiet + 1;
    end
    m_st = ns;
  endtask

  task automatic tick(input string tag);
    logic [3:0] o;
    model_step();
    @(posedge Clock);
    #1;
    chk(tag, obs(), want());
    chk("excl", {31'd0, MT_UP & MT_DOWN}, 32'd0);
    if (plant_en) begin
      o = lamp(m_st);
      if (o[3] && pos < 3) pos++;
      if (o[2] && pos > 0) pos--;
      UpLimit   = (pos == 3);
      DownLimit = (pos == 0);
    end
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 60 && m_st != 0; i++) tick(tag);
    chk({tag, "_idle"}, obs(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    Reset = 0; BoatReq = 0; DeckOccupied = '0;
    UpLimit = 0; DownLimit = 1; pos = 0; plant_en = 1;
    #1 Reset = 1;
    #1 chk("reset", obs(), 32'd0);
    mreset();
    @(negedge Clock);
    Reset = 0;

    // full cycle: warn, raise, open, lower, idle
    BoatReq = 1;
    tick("to_warn");
    BoatReq = 0;
    n = 1;
    for (int i = 0; i < 40 && m_st == 1; i++) begin
      tick("warn");
      if (State == 3'd1) n++;
    end
    chk("warn_len", n, CLR);
    for (int i = 0; i < 40 && m_st == 2; i++) tick("raise");
    n = 1;
    for (int i = 0; i < 40 && m_st == 3; i++) begin
      tick("open");
      if (State == 3'd3) n++;
    end
    chk("open_len", n, HLD);
    settle("cycle1");

    // deck occupied holds WARN past the timer
    BoatReq = 1; DeckOccupied = 4'b0010;
    tick("deck_warn");
    BoatReq = 0;
    repeat (11) tick("deck_hold");
    DeckOccupied = '0;
    tick("deck_clear");
    chk("deck_release", {29'd0, State}, 32'd2);

    // reopen from LOWER
    for (int i = 0; i < 40 && m_st != 4; i++) tick("to_lower");
    tick("lower");
    BoatReq = 1;
    tick("reopen");
    chk("reopen_mot", {30'd0, MT_UP, MT_DOWN}, 32'd2);
    BoatReq = 0;

    // async reset while raising, bridge not down
    #2 Reset = 1;
    #1 chk("async_rst", obs(), 32'd0);
    mreset();
    @(negedge Clock);
    Reset = 0;
    tick("post_rst");
    chk("post_rst_st", {29'd0, State}, 32'd4);
    settle("rst");

`ifdef DRAWBRIDGE_FAULT_EN
    plant_en = 0;
    BoatReq = 1;
    tick("f_warn0");
    BoatReq = 0;
    for (int i = 0; i < 40 && m_st != 2; i++) tick("f_warn");
    DownLimit = 0;
    n = 1;
    for (int i = 0; i < 60 && m_st == 2; i++) begin
      tick("f_raise");
      if (State == 3'd2) n++;
    end
    chk("mot_timeout", n, MTO);
    repeat (5) tick("f_hold");
    chk("fault_out", obs(), 32'h53);
    Reset = 1;
    #1 mreset();
    @(negedge Clock);
    Reset = 0;
    UpLimit = 1; DownLimit = 1;
    tick("both_lim");
    chk("both_fault", {29'd0, State}, 32'd5);
    Reset = 1;
    #1 mreset();
    @(negedge Clock);
    Reset = 0;
    pos = 0; UpLimit = 0; DownLimit = 1;
    plant_en = 1;
`else
    UpLimit = 1; DownLimit = 1;
    tick("both_ign");
    tick("both_ign2");
    UpLimit = 0;
`endif

    // random traffic against the plant
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) BoatReq = ~BoatReq;
      if ($urandom_range(0, 5) == 0)
        DeckOccupied = ND'($urandom);
      else
        DeckOccupied = '0;
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
